pic_bus_master: RTL and testbench
=================================

Name: pic_bus_master

Overview:
- CPU-side initiator for the interrupt controller's bus interface; the other end of the PIC's D/A0/WR/RD/INTA port.
- Turns simple host commands into timed 8259-style bus cycles: ICW init sequence, OCW writes, and status/mask reads.
- Autonomously runs the two-pulse INTA acknowledge when the PIC raises its interrupt, and returns the captured vector.
- Sits between the system controller FSM and the PIC control logic.

Parameters:
- PULSE_CYC, 2, clock cycles each strobe (wr_n/rd_n/inta_n) is held low; legal range 1..15.
- GAP_CYC, 1, clock cycles of recovery, all strobes high, after every strobe; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with no INTA pending.
- cmd_op  in  2  00 write, 01 read, 10 init, 11 reserved (accepted, no bus activity).
- cmd_a0  in  1  A0 for write/read.
- cmd_data  in  8  write data.
- icw1, icw2, icw3, icw4  in  8 each  init values, sampled on init accept.
- rsp_valid  out  1  one-cycle pulse, read data ready.
- rsp_data  out  8  read data, held until the next read.
- int_req  in  1  PIC interrupt output, level.
- vec_valid  out  1  one-cycle pulse, vector captured.
- vec_data  out  8  captured vector, held.
- d_out  out  8  bus data out.
- d_oe  out  1  bus drive enable.
- d_in  in  8  bus data in.
- a0  out  1  address bit.
- cs_n, wr_n, rd_n, inta_n  out  1 each  active-low strobes.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset values: cs_n=wr_n=rd_n=inta_n=1, d_oe=0, d_out=0, a0=0, cmd_ready=0 while rst_n=0, rsp_valid=vec_valid=0, rsp_data=vec_data=0, busy=0.
- Reset asserted mid-cycle forces all strobes high immediately (asynchronous); the sequence is abandoned.
- FSM states: IDLE, STROBE, GAP, ACK_GAP.
- A command is accepted when cmd_valid & cmd_ready. a0, d_out and d_oe (write only) become valid in the next cycle, together with the strobe falling.
- Each bus cycle: STROBE for PULSE_CYC cycles (cs_n low for write/read), then GAP for GAP_CYC cycles.
- Address and data are held stable for the whole STROBE. d_oe drops with the strobe.
- Read: d_in is sampled on the last STROBE cycle. rsp_valid pulses in the first GAP cycle.
- Init: ICW1 (a0=0), then ICW2 (a0=1). ICW3 (a0=1) is issued only if icw1[1]==0 (cascade). ICW4 (a0=1) is issued only if icw1[0]==1. A 3-bit step counter selects the next word. The sequence returns to IDLE after the last GAP.
- INTA: in IDLE, int_req=1 starts the acknowledge sequence.
  - First inta_n pulse, then GAP, then second inta_n pulse. cs_n stays high and d_oe=0 throughout.
  - d_in is sampled on the last low cycle of the second pulse; vec_valid pulses in the following GAP.
  - int_req is not re-evaluated until return to IDLE.
- Arbitration: if int_req and cmd_valid are both present in IDLE in the same cycle, INTA wins and cmd_ready=0 that cycle.
- A strobe counter of 4 bits counts down. PULSE_CYC=1 gives a single-cycle strobe.
- Reserved op: accepted, one idle cycle, then back to IDLE.

Optional Feature:
- PIC_AUTO_EOI_AFTER_ACK_EN.
  - Defined: after vec_valid, the block automatically issues an OCW2 non-specific EOI write (d_out=8'h20, a0=0) through the normal STROBE/GAP timing before returning to IDLE; cmd_ready stays 0 during it.
  - Undefined: the block returns to IDLE directly after the acknowledge GAP.

Decomposition:
- Package pic_bus_pkg:
  - op encodings (OP_WR, OP_RD, OP_INIT).
  - FSM state enum.
  - OCW2 constant EOI_NS=8'h20.
  - ICW1 bit indices IC4_BIT=0, SNGL_BIT=1.
- Sub-module pic_strobe_timer: loads PULSE_CYC/GAP_CYC, reports phase (low/recover) and done.

Test Plan:
- Write (PULSE_CYC=2, GAP_CYC=1), op=00, a0=1, data=8'hFB -> wr_n and cs_n low for exactly 2 cycles with d_out=FB, a0=1, d_oe=1; then 1 gap cycle; busy drops; cmd_ready returns.
- Init with icw1=8'h11 (IC4=1, cascade), icw2=8'h40, icw3=8'h04, icw4=8'h01 -> 4 wr_n pulses, a0 sequence 0,1,1,1, data 11,40,04,01. With icw1=8'h13 -> 3 pulses: 13,40,01, no ICW3.
- Read, a0=0, PIC drives d_in=8'h5A during strobe -> rd_n low 2 cycles, d_oe=0, rsp_valid pulse with rsp_data=5A.
- int_req=1 with d_in=8'h48 on the second pulse -> two inta_n pulses separated by GAP_CYC; cs_n stays high; vec_valid with vec_data=48. With the macro defined, this is followed by a wr_n pulse with d_out=20, a0=0.
- Simultaneous int_req and cmd_valid in IDLE -> INTA sequence runs first; command is accepted afterwards with unchanged data.
- rst_n low during the second inta_n pulse -> inta_n=1 immediately, no vec_valid, FSM in IDLE after release.

Source files
------------

// File: rtl/pic_bus_pkg.sv
// ---------------------------------------------------------------------------
// pic_bus_pkg
// Shared definitions for the 8259-style PIC bus initiator:
//   - host command op encodings
//   - bus FSM state and job encodings
//   - OCW2 non-specific EOI constant and ICW1 bit positions
//   - helper that picks the next word of the ICW init sequence
// ---------------------------------------------------------------------------
package pic_bus_pkg;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_INIT = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_STROBE  = 2'b01,
        ST_GAP     = 2'b10,
        ST_ACK_GAP = 2'b11
    } state_e;

    // What the current bus cycle is doing; drives strobe selection.
    typedef enum logic [2:0] {
        JOB_NONE  = 3'd0,
        JOB_WR    = 3'd1,
        JOB_RD    = 3'd2,
        JOB_INIT  = 3'd3,
        JOB_INTA1 = 3'd4,
        JOB_INTA2 = 3'd5,
        JOB_EOI   = 3'd6
    } job_e;

    localparam logic [7:0] EOI_NS    = 8'h20;
    localparam int         IC4_BIT   = 0;
    localparam int         SNGL_BIT  = 1;
    // Step value meaning "no more ICWs to send".
    localparam logic [2:0] INIT_DONE = 3'd4;

    // Step 0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4. ICW3 only in cascade mode
    // (SNGL=0), ICW4 only when IC4=1.
    function automatic logic [2:0] init_next_step(input logic [2:0] step,
                                                  input logic       sngl,
                                                  input logic       ic4);
        logic [2:0] nxt;
        case (step)
            3'd0:    nxt = 3'd1;
            3'd1:    nxt = (!sngl) ? 3'd2 : (ic4 ? 3'd3 : INIT_DONE);
            3'd2:    nxt = ic4 ? 3'd3 : INIT_DONE;
            default: nxt = INIT_DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// ---------------------------------------------------------------------------
// pic_strobe_timer
// 4-bit down counter timing the strobe-low and recovery phases.
//   clk, rst_n    : clock, async active-low reset
//   load_low_i    : start a strobe-low phase of PULSE_CYC cycles
//   load_gap_i    : start a recovery phase of GAP_CYC cycles
//   done_o        : current cycle is the last one of the running phase
//   phase_low_o   : 1 = strobe-low phase, 0 = recovery phase
// ---------------------------------------------------------------------------
import pic_bus_pkg::*;

module pic_strobe_timer #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_low_i,
    input  logic load_gap_i,
    output logic done_o,
    output logic phase_low_o
);

    logic [3:0] cnt_q, cnt_d;
    logic       phase_low_q, phase_low_d;

    // Next count: load holds N-1 so that a phase lasts exactly N cycles.
    always_comb begin
        cnt_d       = cnt_q;
        phase_low_d = phase_low_q;
        if (load_low_i) begin
            cnt_d       = 4'(PULSE_CYC - 1);
            phase_low_d = 1'b1;
        end else if (load_gap_i) begin
            cnt_d       = 4'(GAP_CYC - 1);
            phase_low_d = 1'b0;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            phase_low_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phase_low_q <= phase_low_d;
        end
    end

    assign done_o      = (cnt_q == 4'd0);
    assign phase_low_o = phase_low_q;

endmodule

// File: rtl/pic_bus_master.sv
// ---------------------------------------------------------------------------
// pic_bus_master
// CPU-side initiator for an 8259-style PIC bus (D/A0/CS/WR/RD/INTA).
// Runs host write/read/init commands as timed bus cycles and autonomously
// performs the two-pulse INTA acknowledge when int_req is raised.
//   host side : cmd_valid/cmd_ready/cmd_op/cmd_a0/cmd_data, icw1..icw4,
//               rsp_valid/rsp_data (reads), vec_valid/vec_data (vectors),
//               busy
//   bus side  : d_out/d_oe/d_in, a0, cs_n, wr_n, rd_n, inta_n, int_req
// Optional build macro PIC_AUTO_EOI_AFTER_ACK_EN: after each captured
// vector, a non-specific EOI (OCW2 = 8'h20, a0=0) is written automatically.
// ---------------------------------------------------------------------------
import pic_bus_pkg::*;

module pic_bus_master #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       int_req,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in,
    output logic       a0,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       inta_n,
    output logic       busy
);

    state_e     state_q, state_d;
    job_e       job_q, job_d;
    logic [2:0] step_q, step_d;
    logic       a0_q, a0_d;
    logic [7:0] dout_q, dout_d;
    logic       ic4_q, ic4_d, sngl_q, sngl_d;
    logic [7:0] icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic       rsp_valid_q, rsp_valid_d, vec_valid_q, vec_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d, vec_data_q, vec_data_d;
    logic       cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic       inta_n_q, inta_n_d, d_oe_q, d_oe_d, busy_q, busy_d;
    logic       idle_ok_q, idle_ok_d;

    logic       load_low_s, load_gap_s, tmr_done_s, tmr_low_s;
    logic       cmd_acc_s, rsvd_acc_s, strobe_on_s, wr_job_s;
    logic [2:0] nxt_step_s;

    pic_strobe_timer #(
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_low_i  (load_low_s),
        .load_gap_i  (load_gap_s),
        .done_o      (tmr_done_s),
        .phase_low_o (tmr_low_s)
    );

    // A pending interrupt blocks command acceptance in the same cycle so
    // INTA always wins arbitration.
    assign cmd_ready = idle_ok_q & ~int_req;
    assign cmd_acc_s = cmd_valid & cmd_ready;

    // Next-state logic for the bus sequencer.
    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        step_d      = step_q;
        a0_d        = a0_q;
        dout_d      = dout_q;
        ic4_d       = ic4_q;
        sngl_d      = sngl_q;
        icw2_d      = icw2_q;
        icw3_d      = icw3_q;
        icw4_d      = icw4_q;
        rsp_data_d  = rsp_data_q;
        vec_data_d  = vec_data_q;
        rsp_valid_d = 1'b0;
        vec_valid_d = 1'b0;
        load_low_s  = 1'b0;
        load_gap_s  = 1'b0;
        rsvd_acc_s  = 1'b0;
        nxt_step_s  = INIT_DONE;
        case (state_q)
            ST_IDLE: begin
                if (int_req) begin
                    state_d    = ST_STROBE;
                    job_d      = JOB_INTA1;
                    load_low_s = 1'b1;
                end else if (cmd_acc_s) begin
                    case (op_e'(cmd_op))
                        OP_WR: begin
                            state_d    = ST_STROBE;
                            job_d      = JOB_WR;
                            a0_d       = cmd_a0;
                            dout_d     = cmd_data;
                            load_low_s = 1'b1;
                        end
                        OP_RD: begin
                            state_d    = ST_STROBE;
                            job_d      = JOB_RD;
                            a0_d       = cmd_a0;
                            load_low_s = 1'b1;
                        end
                        OP_INIT: begin
                            state_d    = ST_STROBE;
                            job_d      = JOB_INIT;
                            step_d     = 3'd0;
                            a0_d       = 1'b0;
                            dout_d     = icw1;
                            ic4_d      = icw1[IC4_BIT];
                            sngl_d     = icw1[SNGL_BIT];
                            icw2_d     = icw2;
                            icw3_d     = icw3;
                            icw4_d     = icw4;
                            load_low_s = 1'b1;
                        end
                        default: begin
                            // Reserved op: swallowed with one not-ready cycle.
                            rsvd_acc_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (tmr_done_s && tmr_low_s) begin
                    // Last low cycle: bus data is sampled here.
                    if (job_q == JOB_RD) begin
                        rsp_data_d  = d_in;
                        rsp_valid_d = 1'b1;
                    end else if (job_q == JOB_INTA2) begin
                        vec_data_d  = d_in;
                        vec_valid_d = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b0;
                    end
                    if (job_q == JOB_INTA1) begin
                        state_d = ST_ACK_GAP;
                    end else begin
                        state_d = ST_GAP;
                    end
                    load_gap_s = 1'b1;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_ACK_GAP: begin
                if (tmr_done_s && !tmr_low_s) begin
                    state_d    = ST_STROBE;
                    job_d      = JOB_INTA2;
                    load_low_s = 1'b1;
                end else begin
                    state_d = ST_ACK_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_done_s && !tmr_low_s) begin
                    case (job_q)
                        JOB_INIT: begin
                            nxt_step_s = init_next_step(step_q, sngl_q, ic4_q);
                            if (nxt_step_s == INIT_DONE) begin
                                state_d = ST_IDLE;
                                job_d   = JOB_NONE;
                            end else begin
                                state_d    = ST_STROBE;
                                step_d     = nxt_step_s;
                                a0_d       = 1'b1;
                                load_low_s = 1'b1;
                                case (nxt_step_s)
                                    3'd1:    dout_d = icw2_q;
                                    3'd2:    dout_d = icw3_q;
                                    default: dout_d = icw4_q;
                                endcase
                            end
                        end
                        JOB_INTA2: begin
`ifdef PIC_AUTO_EOI_AFTER_ACK_EN
                            state_d    = ST_STROBE;
                            job_d      = JOB_EOI;
                            a0_d       = 1'b0;
                            dout_d     = EOI_NS;
                            load_low_s = 1'b1;
`else
                            state_d = ST_IDLE;
                            job_d   = JOB_NONE;
`endif
                        end
                        default: begin
                            state_d = ST_IDLE;
                            job_d   = JOB_NONE;
                        end
                    endcase
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                job_d   = JOB_NONE;
            end
        endcase
    end

    // Strobe/enable values derived from the next state so they are registered
    // and change together with the state.
    always_comb begin
        strobe_on_s = (state_d == ST_STROBE);
        wr_job_s    = (job_d == JOB_WR) || (job_d == JOB_INIT) || (job_d == JOB_EOI);
        cs_n_d      = ~(strobe_on_s && (wr_job_s || (job_d == JOB_RD)));
        wr_n_d      = ~(strobe_on_s && wr_job_s);
        rd_n_d      = ~(strobe_on_s && (job_d == JOB_RD));
        inta_n_d    = ~(strobe_on_s && ((job_d == JOB_INTA1) || (job_d == JOB_INTA2)));
        d_oe_d      = strobe_on_s && wr_job_s;
        busy_d      = (state_d != ST_IDLE);
        idle_ok_d   = (state_d == ST_IDLE) && !rsvd_acc_s;
    end

    // State and output registers; reset forces every strobe high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            job_q       <= JOB_NONE;
            step_q      <= 3'd0;
            a0_q        <= 1'b0;
            dout_q      <= 8'h00;
            ic4_q       <= 1'b0;
            sngl_q      <= 1'b0;
            icw2_q      <= 8'h00;
            icw3_q      <= 8'h00;
            icw4_q      <= 8'h00;
            rsp_valid_q <= 1'b0;
            vec_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            vec_data_q  <= 8'h00;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            inta_n_q    <= 1'b1;
            d_oe_q      <= 1'b0;
            busy_q      <= 1'b0;
            idle_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            step_q      <= step_d;
            a0_q        <= a0_d;
            dout_q      <= dout_d;
            ic4_q       <= ic4_d;
            sngl_q      <= sngl_d;
            icw2_q      <= icw2_d;
            icw3_q      <= icw3_d;
            icw4_q      <= icw4_d;
            rsp_valid_q <= rsp_valid_d;
            vec_valid_q <= vec_valid_d;
            rsp_data_q  <= rsp_data_d;
            vec_data_q  <= vec_data_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            inta_n_q    <= inta_n_d;
            d_oe_q      <= d_oe_d;
            busy_q      <= busy_d;
            idle_ok_q   <= idle_ok_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_data_q;
    assign d_out     = dout_q;
    assign d_oe      = d_oe_q;
    assign a0        = a0_q;
    assign cs_n      = cs_n_q;
    assign wr_n      = wr_n_q;
    assign rd_n      = rd_n_q;
    assign inta_n    = inta_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// ---------------------------------------------------------------------------
// tb_pic_bus_master
// Self-checking bench for pic_bus_master (PULSE_CYC=2, GAP_CYC=1).
// A negedge monitor records every strobe pulse; table vectors cover writes,
// reads, init variants and the reserved op; hand sequences cover INTA,
// arbitration and reset during an acknowledge.
// ---------------------------------------------------------------------------
module tb_pic_bus_master;

    localparam int PULSE = 2;
    localparam int GAP   = 1;
`ifdef PIC_AUTO_EOI_AFTER_ACK_EN
    localparam int ACK_PULSES = 3;
`else
    localparam int ACK_PULSES = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready, cmd_a0, rsp_valid, int_req, vec_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, icw1, icw2, icw3, icw4, rsp_data, vec_data, d_out, d_in;
    logic       d_oe, a0, cs_n, wr_n, rd_n, inta_n, busy;

    pic_bus_master #(.PULSE_CYC(PULSE), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .int_req(int_req),
        .vec_valid(vec_valid), .vec_data(vec_data), .d_out(d_out), .d_oe(d_oe),
        .d_in(d_in), .a0(a0), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .inta_n(inta_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse record: kind 0=write, 1=read, 2=inta.
    typedef struct {
        int         kind;
        logic       a0;
        logic [7:0] dat;
        int         len;
        logic       cs_all, cs_any, oe_all, oe_any, stable;
        int         gap;
    } pulse_t;

    typedef struct {
        logic [1:0]  op;
        logic        a0;
        logic [7:0]  data, i1, i2, i3, i4, din;
        int          n_exp;
        int          kind;
        logic [3:0]  exp_a0;
        logic [31:0] exp_dat;
    } vec_t;

    pulse_t     mon_q[$];
    pulse_t     cur;
    logic       in_pulse = 1'b0, prev_rd_lo = 1'b0, prev_inta_lo = 1'b0;
    int         gap_cnt = 0;
    int         rsp_cnt = 0, vec_cnt = 0;
    logic [7:0] rsp_last = 8'h00, vec_last = 8'h00;
    logic       rsp_tim_bad = 1'b0, vec_tim_bad = 1'b0, oe_bad = 1'b0, rdy_bad = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!wr_n || !rd_n || !inta_n) begin
            if (!in_pulse) begin
                cur.kind   = !wr_n ? 0 : (!rd_n ? 1 : 2);
                cur.a0     = a0;
                cur.dat    = d_out;
                cur.len    = 1;
                cur.cs_all = !cs_n;
                cur.cs_any = !cs_n;
                cur.oe_all = d_oe;
                cur.oe_any = d_oe;
                cur.stable = 1'b1;
                cur.gap    = gap_cnt;
                in_pulse   = 1'b1;
            end else begin
                cur.len++;
                if (a0 !== cur.a0 || d_out !== cur.dat) cur.stable = 1'b0;
                cur.cs_all = cur.cs_all & !cs_n;
                cur.cs_any = cur.cs_any | !cs_n;
                cur.oe_all = cur.oe_all & d_oe;
                cur.oe_any = cur.oe_any | d_oe;
            end
        end else if (in_pulse) begin
            mon_q.push_back(cur);
            in_pulse = 1'b0;
            gap_cnt  = 1;
        end else begin
            gap_cnt++;
        end
        if (d_oe && wr_n) oe_bad = 1'b1;
        if (busy && cmd_ready) rdy_bad = 1'b1;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_last = rsp_data;
            if (!(prev_rd_lo && rd_n)) rsp_tim_bad = 1'b1;
        end
        if (vec_valid) begin
            vec_cnt++;
            vec_last = vec_data;
            if (!(prev_inta_lo && inta_n)) vec_tim_bad = 1'b1;
        end
        prev_rd_lo   = !rd_n;
        prev_inta_lo = !inta_n;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_q.delete();
        rsp_cnt = 0;
        vec_cnt = 0;
    endtask

    // Issue one command after waiting (bounded) for cmd_ready.
    task automatic send_cmd(input logic [1:0] op, input logic a, input logic [7:0] dat);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 32'(n < 100), 32'd1);
        cmd_op = op; cmd_a0 = a; cmd_data = dat; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while ((busy !== 1'b0 || cmd_ready !== 1'b1) && n < 500);
        chk({nm, "_idle_wait"}, 32'(n < 500), 32'd1);
        @(negedge clk); #1;
    endtask

    // which: 0=inta_n, 1=vec_valid, 2=cmd_ready; waits on falling edges.
    task automatic wait_neg(input int which, input logic val, input string nm);
        int   n = 0;
        logic s;
        do begin
            @(negedge clk); n++;
            case (which)
                0:       s = inta_n;
                1:       s = vec_valid;
                default: s = cmd_ready;
            endcase
        end while (s !== val && n < 200);
        chk({nm, "_wait"}, 32'(s === val), 32'd1);
    endtask

    vec_t       vt[9];
    vec_t       v;
    logic [7:0] last_rd;

    initial begin
        //            op     a0    data   icw1   icw2   icw3   icw4   din    n kind a0seq    data seq
        vt[0] = '{2'b00, 1'b1, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 4'b0001, 32'h000000FB};
        vt[1] = '{2'b10, 1'b0, 8'h00, 8'h11, 8'h40, 8'h04, 8'h01, 8'h00, 4, 0, 4'b1110, 32'h01044011};
        vt[2] = '{2'b10, 1'b0, 8'h00, 8'h13, 8'h40, 8'h77, 8'h01, 8'h00, 3, 0, 4'b0110, 32'h00014013};
        vt[3] = '{2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 1, 1, 4'b0000, 32'h00000000};
        vt[4] = '{2'b00, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 4'b0000, 32'h00000020};
        vt[5] = '{2'b10, 1'b0, 8'h00, 8'h12, 8'h48, 8'h33, 8'h44, 8'h00, 2, 0, 4'b0010, 32'h00004812};
        vt[6] = '{2'b10, 1'b0, 8'h00, 8'h10, 8'h48, 8'hFF, 8'h99, 8'h00, 3, 0, 4'b0110, 32'h00FF4810};
        vt[7] = '{2'b11, 1'b1, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 4'b0000, 32'h00000000};
        vt[8] = '{2'b01, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 1, 1, 4'b0001, 32'h00000000};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a0 = 1'b0; cmd_data = 8'h00;
        icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00; int_req = 1'b0; d_in = 8'h00;
        last_rd = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {28'd0, cs_n, wr_n, rd_n, inta_n}, 32'hF);
        chk("rst_bus", {23'd0, d_oe, d_out, a0}, 32'd0);
        chk("rst_host", {12'd0, cmd_ready, rsp_valid, vec_valid, busy, rsp_data, vec_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven commands.
        for (int i = 0; i < 9; i++) begin
            v = vt[i];
            clear_mon();
            icw1 = v.i1; icw2 = v.i2; icw3 = v.i3; icw4 = v.i4; d_in = v.din;
            send_cmd(v.op, v.a0, v.data);
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_npulse", i), mon_q.size(), v.n_exp);
            for (int p = 0; p < v.n_exp; p++) begin
                if (p < mon_q.size()) begin
                    chk($sformatf("v%0d_p%0d_kind", i, p), mon_q[p].kind, v.kind);
                    chk($sformatf("v%0d_p%0d_a0", i, p), {31'd0, mon_q[p].a0}, {31'd0, v.exp_a0[p]});
                    chk($sformatf("v%0d_p%0d_len", i, p), mon_q[p].len, PULSE);
                    chk($sformatf("v%0d_p%0d_cs", i, p), {31'd0, mon_q[p].cs_all}, 32'd1);
                    chk($sformatf("v%0d_p%0d_stable", i, p), {31'd0, mon_q[p].stable}, 32'd1);
                    if (v.kind == 0) begin
                        chk($sformatf("v%0d_p%0d_dat", i, p), {24'd0, mon_q[p].dat}, {24'd0, v.exp_dat[8*p +: 8]});
                        chk($sformatf("v%0d_p%0d_oe", i, p), {31'd0, mon_q[p].oe_all}, 32'd1);
                    end else begin
                        chk($sformatf("v%0d_p%0d_oe", i, p), {31'd0, mon_q[p].oe_any}, 32'd0);
                    end
                    if (p > 0) chk($sformatf("v%0d_p%0d_gap", i, p), mon_q[p].gap, GAP);
                end
            end
            if (v.kind == 1 && v.n_exp == 1) begin
                last_rd = v.din;
                chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt, 1);
                chk($sformatf("v%0d_rsp_last", i), {24'd0, rsp_last}, {24'd0, v.din});
            end else begin
                chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt, 0);
            end
            chk($sformatf("v%0d_rsp_hold", i), {24'd0, rsp_data}, {24'd0, last_rd});
        end
        chk("rsp_timing", {31'd0, rsp_tim_bad}, 32'd0);

        // INTA acknowledge: wrong data on pulse 1, vector 48 on pulse 2.
        clear_mon();
        d_in = 8'hC3;
        int_req = 1'b1;
        wait_neg(0, 1'b0, "ack_p1_low");
        wait_neg(0, 1'b1, "ack_p1_high");
        d_in = 8'h48;
        wait_neg(1, 1'b1, "ack_vec");
        int_req = 1'b0;
        wait_idle("ack");
        chk("ack_npulse", mon_q.size(), ACK_PULSES);
        if (mon_q.size() >= 2) begin
            chk("ack_p1_kind", mon_q[0].kind, 2);
            chk("ack_p2_kind", mon_q[1].kind, 2);
            chk("ack_p1_len", mon_q[0].len, PULSE);
            chk("ack_p2_len", mon_q[1].len, PULSE);
            chk("ack_gap", mon_q[1].gap, GAP);
            chk("ack_cs_high", {30'd0, mon_q[0].cs_any, mon_q[1].cs_any}, 32'd0);
            chk("ack_oe_low", {30'd0, mon_q[0].oe_any, mon_q[1].oe_any}, 32'd0);
        end
`ifdef PIC_AUTO_EOI_AFTER_ACK_EN
        if (mon_q.size() >= 3) begin
            chk("eoi_kind", mon_q[2].kind, 0);
            chk("eoi_dat", {24'd0, mon_q[2].dat}, 32'h20);
            chk("eoi_a0", {31'd0, mon_q[2].a0}, 32'd0);
            chk("eoi_gap", mon_q[2].gap, GAP);
        end
`endif
        chk("ack_vec_cnt", vec_cnt, 1);
        chk("ack_vec_last", {24'd0, vec_last}, 32'h48);
        chk("ack_vec_hold", {24'd0, vec_data}, 32'h48);
        chk("ack_vec_timing", {31'd0, vec_tim_bad}, 32'd0);

        // Arbitration: int_req and a write arrive together.
        clear_mon();
        int_req = 1'b1;
        cmd_op = 2'b00; cmd_a0 = 1'b1; cmd_data = 8'h3C; cmd_valid = 1'b1;
        #1;
        chk("arb_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_neg(1, 1'b1, "arb_vec");
        int_req = 1'b0;
        wait_neg(2, 1'b1, "arb_ready");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle("arb");
        chk("arb_npulse", mon_q.size(), ACK_PULSES + 1);
        if (mon_q.size() == ACK_PULSES + 1) begin
            chk("arb_first_kind", mon_q[0].kind, 2);
            chk("arb_cmd_kind", mon_q[ACK_PULSES].kind, 0);
            chk("arb_cmd_a0", {31'd0, mon_q[ACK_PULSES].a0}, 32'd1);
            chk("arb_cmd_dat", {24'd0, mon_q[ACK_PULSES].dat}, 32'h3C);
        end

        // Reset during the second INTA pulse.
        clear_mon();
        d_in = 8'h99;
        int_req = 1'b1;
        wait_neg(0, 1'b0, "rst_p1_low");
        wait_neg(0, 1'b1, "rst_p1_high");
        wait_neg(0, 1'b0, "rst_p2_low");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_inta", {31'd0, inta_n}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        int_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_vec_cnt", vec_cnt, 0);
        chk("rst_mid_idle", {29'd0, busy, cmd_ready, inta_n}, 32'd3);
        chk("rst_mid_vec_data", {24'd0, vec_data}, 32'd0);

        chk("oe_outside_strobe", {31'd0, oe_bad}, 32'd0);
        chk("ready_while_busy", {31'd0, rdy_bad}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
